// File: rtl/button_conditioner.sv
// Button front end for the snake master: synchronises and debounces four buttons,
// emits press pulses, and keeps the snake heading with reversal rejection.
module button_conditioner #(
    parameter int DB_LIMIT = 50000,
    parameter int DB_W     = 16
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] BTN_RAW,
    input  logic [1:0] STATE_IN,
    output logic [3:0] BTN_LEVEL,
    output logic [3:0] BTN_PRESS,
    output logic [1:0] DIRECTION,
    output logic       DIR_CHANGED
);

    localparam logic [DB_W-1:0] LP_CNT_MAX = DB_W'(DB_LIMIT - 1);
    localparam logic [1:0] LP_ST_IDLE = 2'b00;
    localparam logic [1:0] LP_ST_PLAY = 2'b01;
    localparam logic [1:0] LP_DIR_RIGHT = 2'b01;

    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [DB_W-1:0] r_cnt [4];
    logic [3:0]      r_level;
    logic [3:0]      r_press;
    logic [1:0]      r_dir;
    logic            r_dir_chg;

    logic [1:0]      w_cand;
    logic [1:0]      w_dir_next;
    logic            w_dir_chg_next;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= BTN_RAW;
            r_sync2 <= r_sync1;
        end
    end

    // Level flips only after DB_LIMIT consecutive disagreeing samples; the
    // press pulse is raised on the same edge that sets a level to 1.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_level <= '0;
            r_press <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_CNT_MAX) begin
                    r_level[i] <= r_sync2[i];
                    r_press[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_cand = 2'd0;
        if (r_press[0]) begin
            w_cand = 2'd0;
        end else if (r_press[1]) begin
            w_cand = 2'd1;
        end else if (r_press[2]) begin
            w_cand = 2'd2;
        end else if (r_press[3]) begin
            w_cand = 2'd3;
        end
    end

    // Idle pins the heading to right; only the priority winner of a press
    // event is considered, and a reversal drops the whole event.
    always_comb begin
        w_dir_next     = r_dir;
        w_dir_chg_next = 1'b0;
        if (STATE_IN == LP_ST_IDLE) begin
            w_dir_next = LP_DIR_RIGHT;
        end else if (STATE_IN == LP_ST_PLAY && r_press != 4'b0000) begin
            if (w_cand != (r_dir ^ 2'b10) && w_cand != r_dir) begin
                w_dir_next     = w_cand;
                w_dir_chg_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_dir     <= LP_DIR_RIGHT;
            r_dir_chg <= 1'b0;
        end else begin
            r_dir     <= w_dir_next;
            r_dir_chg <= w_dir_chg_next;
        end
    end

    assign BTN_LEVEL   = r_level;
    assign BTN_PRESS   = r_press;
    assign DIRECTION   = r_dir;
    assign DIR_CHANGED = r_dir_chg;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DB_LIMIT=4): expected output events are
// queued by the stimulus and matched by a free-running monitor.
module tb_button_conditioner;

    logic       CLOCK;
    logic       RESET;
    logic [3:0] BTN_RAW;
    logic [1:0] STATE_IN;
    logic [3:0] BTN_LEVEL;
    logic [3:0] BTN_PRESS;
    logic [1:0] DIRECTION;
    logic       DIR_CHANGED;

    typedef struct {
        logic [3:0] level;
        logic [3:0] press;
        logic [1:0] dir;
        logic       chg;
        int         cyc;
    } evT;

    evT         sbQ [$];
    evT         expEv;
    int         nCompared = 0;
    int         nFailed = 0;
    int         cyc = 0;
    int         c;
    logic [3:0] prevLevel = 4'b0000;
    logic [1:0] prevDir = 2'b01;

    button_conditioner #(.DB_LIMIT(4), .DB_W(16)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .BTN_RAW    (BTN_RAW),
        .STATE_IN   (STATE_IN),
        .BTN_LEVEL  (BTN_LEVEL),
        .BTN_PRESS  (BTN_PRESS),
        .DIRECTION  (DIRECTION),
        .DIR_CHANGED(DIR_CHANGED)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc = cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic applyStimulus(input logic [3:0] raw);
        BTN_RAW = raw;
    endtask

    task automatic expectEvent(input logic [3:0] level, input logic [3:0] press,
                               input logic [1:0] dir, input logic chg, input int at);
        evT e;
        e.level = level;
        e.press = press;
        e.dir   = dir;
        e.chg   = chg;
        e.cyc   = at;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Any visible output activity is an event that must match the queue head.
    always @(negedge CLOCK) begin
        if (!RESET) begin
            prevLevel = 4'b0000;
            prevDir   = 2'b01;
        end else if (BTN_PRESS != 4'b0000 || DIR_CHANGED || BTN_LEVEL != prevLevel ||
                     DIRECTION != prevDir) begin
            nCompared++;
            if (sbQ.size() == 0) begin
                nFailed++;
                $display("[TB] FAIL unexpectedEvent: got level=%b press=%b dir=%b chg=%b cyc=%0d, expected no event",
                         BTN_LEVEL, BTN_PRESS, DIRECTION, DIR_CHANGED, cyc);
            end else begin
                expEv = sbQ.pop_front();
                if (BTN_LEVEL !== expEv.level || BTN_PRESS !== expEv.press ||
                    DIRECTION !== expEv.dir || DIR_CHANGED !== expEv.chg || cyc != expEv.cyc) begin
                    nFailed++;
                    $display("[TB] FAIL event: got level=%b press=%b dir=%b chg=%b cyc=%0d, expected level=%b press=%b dir=%b chg=%b cyc=%0d",
                             BTN_LEVEL, BTN_PRESS, DIRECTION, DIR_CHANGED, cyc,
                             expEv.level, expEv.press, expEv.dir, expEv.chg, expEv.cyc);
                end
            end
            prevLevel = BTN_LEVEL;
            prevDir   = DIRECTION;
        end
    end

    initial begin
        RESET    = 1'b0;
        BTN_RAW  = 4'b0000;
        STATE_IN = 2'b00;
        tick(3);
        #2 RESET = 1'b1;
        tick(1);
        checkOutput("resetLevel", 32'(BTN_LEVEL), 32'h0);
        checkOutput("resetPress", 32'(BTN_PRESS), 32'h0);
        checkOutput("resetDir", 32'(DIRECTION), 32'h1);
        checkOutput("resetChg", 32'(DIR_CHANGED), 32'h0);

        // Clean press and release of up while idle.
        c = cyc; applyStimulus(4'b0001); expectEvent(4'b0001, 4'b0001, 2'b01, 1'b0, c + 6); tick(10);
        c = cyc; applyStimulus(4'b0000); expectEvent(4'b0000, 4'b0000, 2'b01, 1'b0, c + 6); tick(10);

        // Bursts of 3 cycles never reach the 4-cycle limit.
        applyStimulus(4'b0100); tick(3);
        applyStimulus(4'b0000); tick(1);
        applyStimulus(4'b0100); tick(3);
        applyStimulus(4'b0000); tick(10);
        checkOutput("glitchLevel", 32'(BTN_LEVEL), 32'h0);

        STATE_IN = 2'b01; tick(2);
        c = cyc; applyStimulus(4'b1000); expectEvent(4'b1000, 4'b1000, 2'b01, 1'b0, c + 6); tick(10);
        checkOutput("reversalDir", 32'(DIRECTION), 32'h1);
        c = cyc; applyStimulus(4'b0000); expectEvent(4'b0000, 4'b0000, 2'b01, 1'b0, c + 6); tick(10);

        c = cyc; applyStimulus(4'b0001);
        expectEvent(4'b0001, 4'b0001, 2'b01, 1'b0, c + 6);
        expectEvent(4'b0001, 4'b0000, 2'b00, 1'b1, c + 7); tick(10);
        c = cyc; applyStimulus(4'b0000); expectEvent(4'b0000, 4'b0000, 2'b00, 1'b0, c + 6); tick(10);

        c = cyc; applyStimulus(4'b0110);
        expectEvent(4'b0110, 4'b0110, 2'b00, 1'b0, c + 6);
        expectEvent(4'b0110, 4'b0000, 2'b01, 1'b1, c + 7); tick(10);
        c = cyc; applyStimulus(4'b0000); expectEvent(4'b0000, 4'b0000, 2'b01, 1'b0, c + 6); tick(10);

        STATE_IN = 2'b10; tick(2);
        c = cyc; applyStimulus(4'b0100); expectEvent(4'b0100, 4'b0100, 2'b01, 1'b0, c + 6); tick(10);
        checkOutput("winStateDir", 32'(DIRECTION), 32'h1);
        c = cyc; applyStimulus(4'b0000); expectEvent(4'b0000, 4'b0000, 2'b01, 1'b0, c + 6); tick(10);

        // Steer to left (up, then left) so that idle must force it back.
        STATE_IN = 2'b01; tick(2);
        c = cyc; applyStimulus(4'b0001);
        expectEvent(4'b0001, 4'b0001, 2'b01, 1'b0, c + 6);
        expectEvent(4'b0001, 4'b0000, 2'b00, 1'b1, c + 7); tick(10);
        c = cyc; applyStimulus(4'b0000); expectEvent(4'b0000, 4'b0000, 2'b00, 1'b0, c + 6); tick(10);
        c = cyc; applyStimulus(4'b1000);
        expectEvent(4'b1000, 4'b1000, 2'b00, 1'b0, c + 6);
        expectEvent(4'b1000, 4'b0000, 2'b11, 1'b1, c + 7); tick(10);
        c = cyc; applyStimulus(4'b0000); expectEvent(4'b0000, 4'b0000, 2'b11, 1'b0, c + 6); tick(10);

        c = cyc; STATE_IN = 2'b00; expectEvent(4'b0000, 4'b0000, 2'b01, 1'b0, c + 1); tick(3);
        checkOutput("idleChg", 32'(DIR_CHANGED), 32'h0);
        c = cyc; applyStimulus(4'b0010); expectEvent(4'b0010, 4'b0010, 2'b01, 1'b0, c + 6); tick(10);
        checkOutput("idlePressDir", 32'(DIRECTION), 32'h1);

        // Asynchronous reset mid-cycle while a level is held high.
        #2 RESET = 1'b0; applyStimulus(4'b0000);
        #1;
        checkOutput("midResetLevel", 32'(BTN_LEVEL), 32'h0);
        checkOutput("midResetPress", 32'(BTN_PRESS), 32'h0);
        checkOutput("midResetDir", 32'(DIRECTION), 32'h1);
        checkOutput("midResetChg", 32'(DIR_CHANGED), 32'h0);
        tick(2);
        #2 RESET = 1'b1;
        tick(8);
        checkOutput("postResetLevel", 32'(BTN_LEVEL), 32'h0);

        // Partial count before reset must be discarded.
        STATE_IN = 2'b10;
        applyStimulus(4'b0001); tick(3);
        #2 RESET = 1'b0;
        tick(1);
        #2 RESET = 1'b1; c = cyc;
        expectEvent(4'b0001, 4'b0001, 2'b01, 1'b0, c + 6);
        tick(10);
        c = cyc; applyStimulus(4'b0000); expectEvent(4'b0000, 4'b0000, 2'b01, 1'b0, c + 6); tick(10);

        checkOutput("queueEmpty", 32'(sbQ.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
